// File: rtl/ps2_scancode_parser.sv
// PS/2 set-2 scan-code parser: pops bytes from the ps2_keyboard FIFO, strips E0/F0
// prefixes and emits one key event per sequence, tracking the held key and press count.
module ps2_scancode_parser #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic             key_down,
  output logic [7:0]       last_code,
  output logic             last_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err_ovf,
  output logic [1:0]       dbg_state_o
);

  // Event stream: an event is transferred on every cycle with evt_valid=1 and
  // evt_ready=1; fields hold steady while evt_valid=1 and evt_ready=0.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_SETTLE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             evt_valid_q, evt_valid_d;
  logic [7:0]       evt_code_q, evt_code_d;
  logic             evt_ext_q, evt_ext_d;
  logic             evt_brk_q, evt_brk_d;
  logic             evt_rep_q, evt_rep_d;
  logic             key_down_q, key_down_d;
  logic [7:0]       last_code_q, last_code_d;
  logic             last_ext_q, last_ext_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             err_ovf_q, err_ovf_d;

  logic is_filler;
  logic same_key;

  assign is_filler = (byte_q == 8'h00) || (byte_q == 8'hFF) ||
                     (byte_q == 8'hAA) || (byte_q == 8'hFA);
  assign same_key  = ({last_ext_q, last_code_q} == {ext_q, byte_q});

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    nextdata_n_d = 1'b1;
    evt_valid_d  = evt_valid_q;
    evt_code_d   = evt_code_q;
    evt_ext_d    = evt_ext_q;
    evt_brk_d    = evt_brk_q;
    evt_rep_d    = evt_rep_q;
    key_down_d   = key_down_q;
    last_code_d  = last_code_q;
    last_ext_d   = last_ext_q;
    press_cnt_d  = press_cnt_q;
    err_ovf_d    = err_ovf_q | kbd_overflow;

    if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // No fetch while an event is pending, so prefixes cannot race ahead of it.
        if (kbd_ready && !evt_valid_q) begin
          byte_d       = kbd_data;
          nextdata_n_d = 1'b0;
          state_d      = S_POP;
        end
      end
      S_POP: begin
        state_d = S_SETTLE;
        if (byte_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (is_filler) begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else begin
          evt_valid_d = 1'b1;
          evt_code_d  = byte_q;
          evt_ext_d   = ext_q;
          evt_brk_d   = brk_q;
          ext_d       = 1'b0;
          brk_d       = 1'b0;
          if (brk_q) begin
            evt_rep_d = 1'b0;
            if (same_key) begin
              key_down_d = 1'b0;
            end
          end else begin
            evt_rep_d = key_down_q && same_key;
            if (!(key_down_q && same_key)) begin
              press_cnt_d = press_cnt_q + CNT_W'(1);
            end
            key_down_d  = 1'b1;
            last_code_d = byte_q;
            last_ext_d  = ext_q;
          end
        end
      end
      S_SETTLE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= S_IDLE;
      byte_q       <= 8'h00;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      nextdata_n_q <= 1'b1;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= 8'h00;
      evt_ext_q    <= 1'b0;
      evt_brk_q    <= 1'b0;
      evt_rep_q    <= 1'b0;
      key_down_q   <= 1'b0;
      last_code_q  <= 8'h00;
      last_ext_q   <= 1'b0;
      press_cnt_q  <= '0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      nextdata_n_q <= nextdata_n_d;
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      evt_ext_q    <= evt_ext_d;
      evt_brk_q    <= evt_brk_d;
      evt_rep_q    <= evt_rep_d;
      key_down_q   <= key_down_d;
      last_code_q  <= last_code_d;
      last_ext_q   <= last_ext_d;
      press_cnt_q  <= press_cnt_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign kbd_nextdata_n = nextdata_n_q;
  assign evt_valid      = evt_valid_q;
  assign evt_code       = evt_code_q;
  assign evt_ext        = evt_ext_q;
  assign evt_break      = evt_brk_q;
  assign evt_repeat     = evt_rep_q;
  assign key_down       = key_down_q;
  assign last_code      = last_code_q;
  assign last_ext       = last_ext_q;
  assign press_cnt      = press_cnt_q;
  assign err_ovf        = err_ovf_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ps2_scancode_parser.sv
// Bench for ps2_scancode_parser: a byte FIFO stands in for ps2_keyboard, a sequence-level
// model predicts every event, and directed cases pin the model with literal values.
module tb_ps2_scancode_parser;

  localparam int W = 29;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic       kd;
    logic [7:0] lc;
    logic       le;
    logic [7:0] pc;
  } ev_t;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_ready = 1'b0;
  logic       kbd_overflow = 1'b0;
  logic       kbd_nextdata_n;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_repeat;
  logic       key_down;
  logic [7:0] last_code;
  logic       last_ext;
  logic [7:0] press_cnt;
  logic       err_ovf;
  logic [1:0] dbg_state;

  ps2_scancode_parser #(.CNT_W(8)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_code       (evt_code),
    .evt_ext        (evt_ext),
    .evt_break      (evt_break),
    .evt_repeat     (evt_repeat),
    .key_down       (key_down),
    .last_code      (last_code),
    .last_ext       (last_ext),
    .press_cnt      (press_cnt),
    .err_ovf        (err_ovf),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int pop_cnt  = 0;
  int n_pushed = 0;

  logic [7:0]   fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (sequence level) ----------------
  logic       m_ext, m_brk, m_kd, m_le;
  logic [7:0] m_lc, m_pc;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_kd = 0; m_le = 0; m_lc = 8'h00; m_pc = 8'h00;
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    logic same;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b inside {8'h00, 8'hFF, 8'hAA, 8'hFA}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      same = m_kd && (m_lc == b) && (m_le == m_ext);
      e.code = b; e.ext = m_ext; e.brk = m_brk;
      e.rep  = !m_brk && same;
      if (!m_brk) begin
        if (!same) m_pc = m_pc + 8'd1;
        m_kd = 1; m_lc = b; m_le = m_ext;
      end else if (m_lc == b && m_le == m_ext) begin
        m_kd = 0;
      end
      e.kd = m_kd; e.lc = m_lc; e.le = m_le; e.pc = m_pc;
      exp_q.push_back(W'(e));
      m_ext = 0; m_brk = 0;
    end
  endtask

  // ---------------- FIFO standing in for ps2_keyboard ----------------
  initial begin
    logic p, prev_p;
    prev_p = 0;
    forever begin
      @(negedge clk);
      p = !kbd_nextdata_n && clrn;
      chk("pop_pulse_single", {31'b0, p && prev_p}, 32'd0);
      prev_p = p;
      @(posedge clk);
      #1;
      if (p) begin
        pop_cnt++;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        else chk("pop_from_empty", 32'd1, 32'd0);
      end
      kbd_ready = (fifo_q.size() != 0);
      kbd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    ev_t e, a;
    if (clrn && evt_valid) begin
      a.code = evt_code; a.ext = evt_ext; a.brk = evt_break; a.rep = evt_repeat;
      a.kd = key_down; a.lc = last_code; a.le = last_ext; a.pc = press_cnt;
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {24'b0, evt_code}, 32'hFFFF_FFFF);
      end else begin
        e = ev_t'(exp_q[0]);
        chk("evt_code",   {24'b0, a.code}, {24'b0, e.code});
        chk("evt_ext",    {31'b0, a.ext},  {31'b0, e.ext});
        chk("evt_break",  {31'b0, a.brk},  {31'b0, e.brk});
        chk("evt_repeat", {31'b0, a.rep},  {31'b0, e.rep});
        chk("key_down",   {31'b0, a.kd},   {31'b0, e.kd});
        chk("last_code",  {24'b0, a.lc},   {24'b0, e.lc});
        chk("last_ext",   {31'b0, a.le},   {31'b0, e.le});
        chk("press_cnt",  {24'b0, a.pc},   {24'b0, e.pc});
        if (evt_ready) begin
          void'(exp_q.pop_front());
          acc_q.push_back(W'(a));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    model_byte(b);
    fifo_q.push_back(b);
    n_pushed++;
  endtask

  task automatic do_reset();
    clrn = 0;
    model_reset();
    step();
    step();
    clrn = 1;
    step();
  endtask

  task automatic wait_idle();
    int quiet;
    bit ok;
    quiet = 0;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (fifo_q.size() == 0 && !evt_valid && kbd_nextdata_n && dbg_state == 2'd0) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  function automatic ev_t acc(input int i);
    return ev_t'(acc_q[i]);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int p0;
    model_reset();
    step();
    do_reset();

    // reset values
    chk("rst_nextdata_n", {31'b0, kbd_nextdata_n}, 32'd1);
    chk("rst_evt_valid",  {31'b0, evt_valid}, 32'd0);
    chk("rst_evt_fields", {21'b0, evt_code, evt_ext, evt_break, evt_repeat}, 32'd0);
    chk("rst_key_state",  {22'b0, key_down, last_code, last_ext}, 32'd0);
    chk("rst_press_cnt",  {24'b0, press_cnt}, 32'd0);
    chk("rst_err_ovf",    {31'b0, err_ovf}, 32'd0);

    // single make
    p0 = pop_cnt;
    push(8'h1C);
    wait_idle();
    chk("t1_pops", pop_cnt - p0, 32'd1);
    chk("t1_events", acc_q.size(), 32'd1);
    if (acc_q.size() >= 1) chk("t1_evt", {3'b0, acc(0).code, acc(0).ext, acc(0).brk, acc(0).rep, 17'b0}, {3'b0, 8'h1C, 3'b000, 17'b0});
    chk("t1_press_cnt", {24'b0, press_cnt}, 32'd1);
    chk("t1_key_down", {31'b0, key_down}, 32'd1);
    chk("t1_last_code", {24'b0, last_code}, 32'h1C);

    // make then break
    do_reset();
    p0 = pop_cnt;
    push(8'h1C); push(8'hF0); push(8'h1C);
    wait_idle();
    chk("t2_pops", pop_cnt - p0, 32'd3);
    chk("t2_events", acc_q.size(), 32'd2);
    if (acc_q.size() >= 2) chk("t2_evt2", {23'b0, acc(1).code, acc(1).brk}, {23'b0, 8'h1C, 1'b1});
    chk("t2_key_down", {31'b0, key_down}, 32'd0);
    chk("t2_press_cnt", {24'b0, press_cnt}, 32'd1);

    // extended make/break
    do_reset();
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    wait_idle();
    chk("t3_events", acc_q.size(), 32'd2);
    if (acc_q.size() >= 2) begin
      chk("t3_evt1", {22'b0, acc(0).code, acc(0).ext, acc(0).brk}, {22'b0, 8'h75, 2'b10});
      chk("t3_evt2", {22'b0, acc(1).code, acc(1).ext, acc(1).brk}, {22'b0, 8'h75, 2'b11});
    end
    chk("t3_last_ext", {31'b0, last_ext}, 32'd1);
    chk("t3_press_cnt", {24'b0, press_cnt}, 32'd1);

    // typematic repeats
    do_reset();
    push(8'h1C); push(8'h1C); push(8'h1C);
    wait_idle();
    chk("t4_events", acc_q.size(), 32'd3);
    if (acc_q.size() >= 3) chk("t4_repeats", {29'b0, acc(0).rep, acc(1).rep, acc(2).rep}, 32'b011);
    chk("t4_press_cnt", {24'b0, press_cnt}, 32'd1);

    // backpressure
    do_reset();
    evt_ready = 0;
    p0 = pop_cnt;
    push(8'h1C); push(8'h32);
    repeat (20) step();
    chk("t5_pops_held", pop_cnt - p0, 32'd1);
    chk("t5_valid_held", {31'b0, evt_valid}, 32'd1);
    chk("t5_code_held", {24'b0, evt_code}, 32'h1C);
    evt_ready = 1;
    wait_idle();
    chk("t5_events", acc_q.size(), 32'd2);
    if (acc_q.size() >= 2) chk("t5_evt2_code", {24'b0, acc(1).code}, 32'h32);
    chk("t5_pops", pop_cnt - p0, 32'd2);

    // reset mid-SETTLE discards the pending break prefix
    do_reset();
    push(8'h1C);
    wait_idle();
    push(8'hF0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
        step();
        if (!kbd_nextdata_n) begin
          seen = 1;
          break;
        end
      end
      chk("t6_pop_seen", {31'b0, seen}, 32'd1);
    end
    step();
    chk("t6_in_settle", {30'b0, dbg_state}, 32'd2);
    clrn = 0;
    model_reset();
    #1;
    chk("t6_rst_outputs", {10'b0, kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_break, evt_repeat, key_down, last_code},
        {10'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 8'h00});
    chk("t6_rst_cnt", {23'b0, press_cnt, last_ext}, 32'd0);
    step();
    clrn = 1;
    step();
    push(8'h1C);
    wait_idle();
    chk("t6_events", acc_q.size(), 32'd1);
    if (acc_q.size() >= 1) chk("t6_is_make", {31'b0, acc(0).brk}, 32'd0);
    chk("t6_press_cnt", {24'b0, press_cnt}, 32'd1);

    // overflow is sticky until reset
    chk("t7_ovf_before", {31'b0, err_ovf}, 32'd0);
    kbd_overflow = 1;
    step();
    kbd_overflow = 0;
    chk("t7_ovf_set", {31'b0, err_ovf}, 32'd1);
    repeat (10) step();
    chk("t7_ovf_sticky", {31'b0, err_ovf}, 32'd1);
    do_reset();
    chk("t7_ovf_cleared", {31'b0, err_ovf}, 32'd0);

    // press counter wraps: 260 alternating makes
    for (int i = 0; i < 260; i++) begin
      push((i % 2 == 0) ? 8'h1C : 8'h32);
      wait_idle();
    end
    chk("t8_press_cnt_wrap", {24'b0, press_cnt}, 32'd4);

    // randomized traffic with random backpressure
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      int r;
      step();
      evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) begin
        r = $urandom_range(0, 15);
        if (r <= 2) push(8'hE0);
        else if (r <= 5) push(8'hF0);
        else if (r == 6) push(8'hAA);
        else if (r <= 9) push(8'h1C);
        else if (r <= 11) push(8'h75);
        else push(8'($urandom_range(0, 255)));
      end
    end
    evt_ready = 1;
    wait_idle();
    chk("rand_exp_drained", exp_q.size(), 32'd0);
    chk("total_pops", pop_cnt, n_pushed);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_parser.md
Name:
ps2_scancode_parser

Overview:
- Sits directly downstream of ps2_keyboard and consumes its byte FIFO through the data/ready/nextdata_n interface.
- Strips the PS/2 set-2 prefixes (E0 extended, F0 break) and emits one key event per complete scan-code sequence on a valid/ready stream.
- Also tracks the held key, flags typematic repeats and counts distinct key presses for display/LED logic.

Parameters:
- CNT_W, 8, width of the press counter press_cnt.

Ports:
- clk  in  1  system clock; all state on rising edge.
- clrn  in  1  asynchronous active-low reset.
- kbd_data  in  8  byte at FIFO head of ps2_keyboard.
- kbd_ready  in  1  FIFO non-empty.
- kbd_overflow  in  1  FIFO overflow flag from ps2_keyboard.
- kbd_nextdata_n  out  1  active-low pop request to ps2_keyboard.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_code  out  8  base scan code, prefixes removed.
- evt_ext  out  1  sequence carried an E0 prefix.
- evt_break  out  1  sequence carried an F0 prefix (key release).
- evt_repeat  out  1  make event is a typematic repeat of the held key.
- key_down  out  1  last pressed key still held.
- last_code  out  8  code of the last make event.
- last_ext  out  1  ext flag of the last make event.
- press_cnt  out  CNT_W  count of non-repeat make events, wraps.
- err_ovf  out  1  sticky: kbd_overflow seen high.

Behaviour:
- Reset (clrn low, asynchronous): FSM to IDLE.
  - kbd_nextdata_n=1; evt_valid=0; evt_code/evt_ext/evt_break/evt_repeat=0.
  - key_down=0; last_code=0; last_ext=0; press_cnt=0; err_ovf=0.
  - Internal prefix flags ext_r and brk_r cleared.
  - Reset mid-sequence discards any pending prefix.
- FSM states: IDLE, POP, SETTLE.
  - IDLE: if kbd_ready=1 and evt_valid=0, latch kbd_data into byte_r and go to POP. Otherwise stay in IDLE.
  - POP: kbd_nextdata_n=0 for exactly this one cycle (registered output). byte_r is decoded here. Always go to SETTLE.
  - SETTLE: kbd_nextdata_n=1 for one cycle so that FIFO ready settles. Go to IDLE.
  - Result: exactly one low pulse per consumed byte. Maximum throughput is one byte per 3 cycles.
- Decode in POP, applied at the edge that leaves POP:
  - 0xE0: set ext_r. No event.
  - 0xF0: set brk_r. No event.
  - 0x00, 0xFF, 0xAA, 0xFA: discard; clear ext_r and brk_r. No event.
  - Any other byte: evt_valid=1; evt_code=byte_r; evt_ext=ext_r; evt_break=brk_r. Then clear ext_r and brk_r.
- Make handling (brk_r=0):
  - evt_repeat=1 if key_down=1 and {last_ext,last_code} equals {ext_r,byte_r}; otherwise 0.
  - If not a repeat, press_cnt increments modulo 2^CNT_W.
  - key_down=1; last_code=byte_r; last_ext=ext_r.
- Break handling (brk_r=1):
  - evt_repeat=0.
  - key_down clears only if {ext_r,byte_r} equals {last_ext,last_code}. A break for a different key leaves key_down unchanged.
  - press_cnt is unchanged.
- Event handshake:
  - evt_valid rises 2 cycles after the IDLE cycle that saw kbd_ready.
  - Event fields stay stable while evt_valid=1.
  - evt_valid clears on any cycle with evt_valid=1 and evt_ready=1.
  - While evt_valid=1, IDLE does not fetch. FIFO backpressure then comes from the ps2_keyboard FIFO itself.
- Overflow: err_ovf is set on any cycle with kbd_overflow=1 and is cleared only by reset. It does not affect parsing.

Test Plan:
- Reset, then bytes 0x1C (with evt_ready=1) -> exactly one kbd_nextdata_n low pulse. Event: code=0x1C, ext=0, break=0, repeat=0. press_cnt=1, key_down=1, last_code=0x1C.
- Bytes 0x1C, 0xF0, 0x1C -> 3 pops, 2 events. Second event: code=0x1C, break=1. key_down=0, press_cnt=1.
- Bytes 0xE0, 0x75, 0xE0, 0xF0, 0x75 -> 2 events, both code=0x75 and ext=1; the second has break=1. last_ext=1, press_cnt=1.
- Bytes 0x1C, 0x1C, 0x1C -> 3 events with repeat=0, 1, 1. press_cnt=1.
- Bytes 0x1C, 0x32 queued, with evt_ready=0 for 20 cycles -> first event is held stable and only 1 pop occurs. After evt_ready=1, the second event (code=0x32) appears.
- Byte 0xF0, then clrn pulsed low mid-SETTLE, then byte 0x1C -> all outputs return to reset values. The resulting event is a make: break=0, press_cnt=1.
- kbd_overflow high for 1 cycle -> err_ovf=1 and stays 1 until clrn.
